regfile_scoreboard: RTL and testbench



---
 rtl/regfile_pkg.sv | 29 ++
 rtl/regfile_scoreboard_busy.sv | 77 +++++++
 rtl/regfile_scoreboard.sv | 152 +++++++++++++++
 tb/tb_regfile_scoreboard.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared types and defaults for the integer register file with scoreboard.
//   rf_state_e : clear-sequencer states (CLEAR while zeroing, RUN afterwards)
//   *_DEF      : default data width, register count and read-port count
//   calc_aw()  : address width needed to index n registers
// ---------------------------------------------------------------------------
package regfile_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NRP_DEF  = 2;

    // Counts the powers of two below n, which is ceil(log2(n)).
    function automatic int calc_aw(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            w = w + int'((32'd1 << i) < n);
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_busy.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard_busy
// Per-register busy bits marking registers with an outstanding long-latency
// writeback. Update priority: flush > set > clear-on-write. Bit 0 is never
// busy.
// Ports:
//   clk, rst       clock / asynchronous active-low reset
//   en             updates allowed (low while the array is being cleared)
//   flush          clear every busy bit
//   bset/bset_addr mark one register busy
//   wren/waddr     writeback retires the busy bit of waddr
//   raddr          flat per-port read addresses
//   busy_cur       registered busy bit per port
//   busy_nxt       busy bit per port after this cycle's update (for bypass)
// ---------------------------------------------------------------------------
module regfile_scoreboard_busy
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int NRP  = NRP_DEF,
    localparam int AW  = calc_aw(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic              bset,
    input  logic [AW-1:0]     bset_addr,
    input  logic              wren,
    input  logic [AW-1:0]     waddr,
    input  logic [NRP*AW-1:0] raddr,
    output logic [NRP-1:0]    busy_cur,
    output logic [NRP-1:0]    busy_nxt
);

    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;

    // Next busy vector: a new producer (set) supersedes a same-cycle writeback.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int j = 0; j < NREG; j++) begin
            if (!en) begin
                busy_nxt_s[j] = busy_r[j];
            end else if (flush) begin
                busy_nxt_s[j] = 1'b0;
            end else if (bset && (bset_addr == AW'(j))) begin
                busy_nxt_s[j] = 1'b1;
            end else if (wren && (waddr == AW'(j))) begin
                busy_nxt_s[j] = 1'b0;
            end else begin
                busy_nxt_s[j] = busy_r[j];
            end
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Busy vector storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Per-port lookup of current and post-update busy bits.
    always_comb begin
        busy_cur = '0;
        busy_nxt = '0;
        for (int i = 0; i < NRP; i++) begin
            busy_cur[i] = busy_r[raddr[i*AW +: AW]];
            busy_nxt[i] = busy_nxt_s[raddr[i*AW +: AW]];
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Parametrised integer register file (x0 hardwired to zero) with optional
// write-to-read bypass and per-register busy bits. After reset a sequencer
// zeroes entries 1..NREG-1, one per cycle, then raises ready.
// Ports:
//   clk, rst           clock / asynchronous active-low reset
//   ready              high once the clear sequence has finished
//   rden, raddr        per-port read enable / address (port i at [i*AW +: AW])
//   rdata, rbusy       per-port read data (port i at [i*XLEN +: XLEN]) / busy
//   wren, waddr, wdata write port
//   bset, bset_addr    mark a register busy
//   flush              clear all busy bits
// ---------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int NRP    = NRP_DEF,
    parameter int BYPASS = 1,
    localparam int AW    = calc_aw(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic [NRP-1:0]      rden,
    input  logic [NRP*AW-1:0]   raddr,
    output logic [NRP*XLEN-1:0] rdata,
    output logic [NRP-1:0]      rbusy,
    input  logic                wren,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic                bset,
    input  logic [AW-1:0]       bset_addr,
    input  logic                flush
);

    localparam logic [AW-1:0] ADDR_ZERO = AW'(0);
    localparam logic [AW-1:0] CNT_ONE   = AW'(1);
    localparam logic [AW-1:0] CNT_LAST  = AW'(NREG - 1);

    rf_state_e           state_r;
    logic [AW-1:0]       clr_cnt_r;
    logic                ready_r;
    logic [XLEN-1:0]     mem_r [NREG];

    logic                run_s;
    logic                we_s;
    logic [AW-1:0]       wa_s;
    logic [XLEN-1:0]     wd_s;
    logic [NRP-1:0]      busy_cur_s;
    logic [NRP-1:0]      busy_nxt_s;
    logic [NRP*XLEN-1:0] rdata_s;
    logic [NRP-1:0]      rbusy_s;

    assign run_s = (state_r == RUN);
    assign ready = ready_r;
    assign rdata = rdata_s;
    assign rbusy = rbusy_s;

    // Clear sequencer: walks entries 1..NREG-1 then parks in RUN until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= CLEAR;
            clr_cnt_r <= CNT_ONE;
            ready_r   <= 1'b0;
        end else begin
            case (state_r)
                CLEAR: begin
                    if (clr_cnt_r == CNT_LAST) begin
                        state_r <= RUN;
                        ready_r <= 1'b1;
                    end else begin
                        clr_cnt_r <= clr_cnt_r + CNT_ONE;
                        ready_r   <= 1'b0;
                    end
                end
                RUN: begin
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r   <= CLEAR;
                    clr_cnt_r <= CNT_ONE;
                    ready_r   <= 1'b0;
                end
            endcase
        end
    end

    // Write-port arbitration: the clear sequencer owns the port during CLEAR.
    always_comb begin
        if (state_r == CLEAR) begin
            we_s = 1'b1;
            wa_s = clr_cnt_r;
            wd_s = '0;
        end else if (wren && (waddr != ADDR_ZERO)) begin
            we_s = 1'b1;
            wa_s = waddr;
            wd_s = wdata;
        end else begin
            we_s = 1'b0;
            wa_s = waddr;
            wd_s = wdata;
        end
    end

    // Storage array; deliberately not reset, the sequencer zeroes it.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[wa_s] <= wd_s;
        end
    end

    regfile_scoreboard_busy #(
        .NREG (NREG),
        .NRP  (NRP)
    ) u_busy (
        .clk       (clk),
        .rst       (rst),
        .en        (run_s),
        .flush     (flush),
        .bset      (bset),
        .bset_addr (bset_addr),
        .wren      (wren),
        .waddr     (waddr),
        .raddr     (raddr),
        .busy_cur  (busy_cur_s),
        .busy_nxt  (busy_nxt_s)
    );

    // Zero-latency read ports; a bypassed read reports the post-update busy bit.
    always_comb begin
        rdata_s = '0;
        rbusy_s = '0;
        for (int i = 0; i < NRP; i++) begin
            if (run_s && rden[i] && (raddr[i*AW +: AW] != ADDR_ZERO)) begin
                if ((BYPASS != 0) && wren && (waddr == raddr[i*AW +: AW])) begin
                    rdata_s[i*XLEN +: XLEN] = wdata;
                    rbusy_s[i]              = busy_nxt_s[i];
                end else begin
                    rdata_s[i*XLEN +: XLEN] = mem_r[raddr[i*AW +: AW]];
                    rbusy_s[i]              = busy_cur_s[i];
                end
            end else begin
                rdata_s[i*XLEN +: XLEN] = '0;
                rbusy_s[i]              = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_scoreboard
// Drives a bypassing and a non-bypassing 32-entry file from shared stimulus,
// plus a 16-entry file sharing the reset, and compares read results against
// a table of expected values routed through a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  rden;
    logic [9:0]  raddr;
    logic        wren;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        bset;
    logic [4:0]  bset_addr;
    logic        flush;

    logic        ready, ready_nb, ready16;
    logic [63:0] rdata, rdata_nb, rdata16;
    logic [1:0]  rbusy, rbusy_nb, rbusy16;

    logic [7:0]  raddr16;
    logic        wren16;
    logic [3:0]  waddr16;
    logic [31:0] wdata16;

    regfile_scoreboard #(.XLEN(32), .NREG(32), .NRP(2), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .ready(ready), .rden(rden), .raddr(raddr),
        .rdata(rdata), .rbusy(rbusy), .wren(wren), .waddr(waddr),
        .wdata(wdata), .bset(bset), .bset_addr(bset_addr), .flush(flush));

    regfile_scoreboard #(.XLEN(32), .NREG(32), .NRP(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .ready(ready_nb), .rden(rden), .raddr(raddr),
        .rdata(rdata_nb), .rbusy(rbusy_nb), .wren(wren), .waddr(waddr),
        .wdata(wdata), .bset(bset), .bset_addr(bset_addr), .flush(flush));

    regfile_scoreboard #(.XLEN(32), .NREG(16), .NRP(2), .BYPASS(1)) dut16 (
        .clk(clk), .rst(rst), .ready(ready16), .rden(2'b11), .raddr(raddr16),
        .rdata(rdata16), .rbusy(rbusy16), .wren(wren16), .waddr(waddr16),
        .wdata(wdata16), .bset(1'b0), .bset_addr(4'd0), .flush(1'b0));

    typedef struct {
        logic        wren;  logic [4:0] wa; logic [31:0] wd;
        logic        bset;  logic [4:0] ba; logic flush;
        logic [1:0]  rden;  logic [4:0] ra0; logic [4:0] ra1;
        logic [31:0] e0;    logic [31:0] e1; logic [1:0] eb;
        logic [31:0] n0;    logic [31:0] n1; logic [1:0] nb;
    } vec_t;

    typedef struct {
        int          row;
        logic [31:0] e0; logic [31:0] e1; logic [1:0] eb;
        logic [31:0] n0; logic [31:0] n1; logic [1:0] nb;
    } exp_t;

    localparam int NV = 18;
    vec_t tbl [NV];
    exp_t exp_q [$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        rden = 2'b00; raddr = 10'd0; wren = 1'b0; waddr = 5'd0; wdata = 32'd0;
        bset = 1'b0; bset_addr = 5'd0; flush = 1'b0;
        raddr16 = 8'd0; wren16 = 1'b0; waddr16 = 4'd0; wdata16 = 32'd0;
    endtask

    // Counts rising edges after reset release until ready, for both sizes.
    task automatic clear_wait(input string nm);
        int n;
        int n16;
        n = 0;
        n16 = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (ready16 && n16 == 0) n16 = k;
            if (ready) begin
                n = k;
                break;
            end
        end
        chk({nm, "_len32"}, 64'(n), 64'd31);
        chk({nm, "_len16"}, 64'(n16), 64'd15);
        chk({nm, "_ready_nb"}, 64'(ready_nb), 64'd1);
    endtask

    task automatic read2(input logic [4:0] a0, input logic [4:0] a1);
        @(negedge clk);
        idle();
        rden  = 2'b11;
        raddr = {a1, a0};
        #1;
    endtask

    initial begin
        // cycle rows: wren wa wd bset ba flush rden ra0 ra1 | e0 e1 eb | n0 n1 nb
        tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 2'b11, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00};
        tbl[1]  = '{1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 1'b0, 2'b11, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00, 32'hDEADBEEF, 32'h0, 2'b00};
        tbl[2]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 2'b11, 5'd7, 5'd5, 32'hA5A5A5A5, 32'hDEADBEEF, 2'b00, 32'h0, 32'hDEADBEEF, 2'b00};
        tbl[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 2'b01, 5'd7, 5'd7, 32'hA5A5A5A5, 32'h0, 2'b00, 32'hA5A5A5A5, 32'h0, 2'b00};
        tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 2'b11, 5'd9, 5'd7, 32'h0, 32'hA5A5A5A5, 2'b00, 32'h0, 32'hA5A5A5A5, 2'b00};
        tbl[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 2'b11, 5'd9, 5'd9, 32'h0, 32'h0, 2'b11, 32'h0, 32'h0, 2'b11};
        tbl[6]  = '{1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 1'b0, 2'b11, 5'd9, 5'd9, 32'h1, 32'h1, 2'b00, 32'h0, 32'h0, 2'b11};
        tbl[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 2'b11, 5'd9, 5'd9, 32'h1, 32'h1, 2'b00, 32'h1, 32'h1, 2'b00};
        tbl[8]  = '{1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 1'b0, 2'b11, 5'd9, 5'd9, 32'h1, 32'h1, 2'b11, 32'h1, 32'h1, 2'b00};
        tbl[9]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 2'b11, 5'd9, 5'd9, 32'h1, 32'h1, 2'b11, 32'h1, 32'h1, 2'b11};
        tbl[10] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 2'b11, 5'd3, 5'd4, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00};
        tbl[11] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 2'b11, 5'd3, 5'd4, 32'h0, 32'h0, 2'b01, 32'h0, 32'h0, 2'b01};
        tbl[12] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b1, 2'b11, 5'd3, 5'd4, 32'h0, 32'h0, 2'b11, 32'h0, 32'h0, 2'b11};
        tbl[13] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 2'b11, 5'd3, 5'd4, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00};
        tbl[14] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 2'b11, 5'd6, 5'd9, 32'h0, 32'h1, 2'b00, 32'h0, 32'h1, 2'b00};
        tbl[15] = '{1'b1, 5'd1, 32'hFF, 1'b0, 5'd0, 1'b0, 2'b11, 5'd1, 5'd1, 32'hFF, 32'hFF, 2'b00, 32'h0, 32'h0, 2'b00};
        tbl[16] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 2'b11, 5'd1, 5'd5, 32'hFF, 32'hDEADBEEF, 2'b00, 32'hFF, 32'hDEADBEEF, 2'b00};
        tbl[17] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0, 2'b11, 5'd2, 5'd2, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00};

        // Reset held: everything idle and not ready.
        idle();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rden = 2'b11; raddr = {5'd3, 5'd5};
        #1;
        chk("rst_ready", {ready16, ready_nb, ready}, 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_rbusy", rbusy, 64'd0);

        // Release and time the first clear sequence.
        @(negedge clk);
        idle();
        rst = 1'b1;
        clear_wait("clr1");

        // Every register reads zero on both ports.
        for (int r = 0; r < 32; r++) begin
            read2(5'(r), 5'(31 - r));
            chk($sformatf("zero_x%0d", r), rdata, 64'd0);
        end
        read2(5'd0, 5'd0);
        raddr16 = {4'd0, 4'd15};
        #1;
        chk("zero16_x15", rdata16, 64'd0);

        // Table-driven cycles through the scoreboard queue.
        for (int i = 0; i < NV; i++) begin
            exp_t e;
            @(negedge clk);
            idle();
            wren = tbl[i].wren; waddr = tbl[i].wa; wdata = tbl[i].wd;
            bset = tbl[i].bset; bset_addr = tbl[i].ba; flush = tbl[i].flush;
            rden = tbl[i].rden; raddr = {tbl[i].ra1, tbl[i].ra0};
            exp_q.push_back('{i, tbl[i].e0, tbl[i].e1, tbl[i].eb, tbl[i].n0, tbl[i].n1, tbl[i].nb});
            #1;
            e = exp_q.pop_front();
            chk($sformatf("row%0d_rdata", e.row), rdata, {e.e1, e.e0});
            chk($sformatf("row%0d_rbusy", e.row), rbusy, 64'(e.eb));
            chk($sformatf("row%0d_rdata_nb", e.row), rdata_nb, {e.n1, e.n0});
            chk($sformatf("row%0d_rbusy_nb", e.row), rbusy_nb, 64'(e.nb));
        end
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        // NREG=16 write then read back.
        @(negedge clk);
        idle();
        wren16 = 1'b1; waddr16 = 4'd15; wdata16 = 32'h0000CAFE;
        @(negedge clk);
        idle();
        raddr16 = {4'd0, 4'd15};
        #1;
        chk("nreg16_rw", rdata16, 64'h0000_0000_0000_CAFE);

        // x2 busy before reset in RUN.
        read2(5'd2, 5'd1);
        chk("pre_rst_busy", rbusy, 64'd1);
        rst = 1'b0;
        #1;
        chk("run_rst_ready", {ready16, ready_nb, ready}, 64'd0);
        chk("run_rst_rbusy", rbusy, 64'd0);
        chk("run_rst_rdata", rdata, 64'd0);

        // Release, attempt writes/sets during CLEAR, reset again at count 10.
        @(negedge clk);
        rst = 1'b1;
        wren = 1'b1; waddr = 5'd2; wdata = 32'hFFFF;
        bset = 1'b1; bset_addr = 5'd2;
        #1;
        chk("clear_rdata", rdata, 64'd0);
        chk("clear_rbusy", rbusy, 64'd0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        idle();
        rst = 1'b0;
        #1;
        chk("mid_clear_ready", {ready16, ready_nb, ready}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        clear_wait("clr2");

        read2(5'd1, 5'd2);
        chk("post_x1_x2", rdata, 64'd0);
        chk("post_busy", rbusy, 64'd0);
        read2(5'd5, 5'd7);
        chk("post_x5_x7", rdata, 64'd0);
        raddr16 = {4'd0, 4'd15};
        #1;
        chk("post16_x15", rdata16, 64'd0);
        chk("post16_busy", rbusy16, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
